// File: rtl/mem_access_ctrl.sv
// Memory-access controller in front of the byte-lane data RAM: drives lane-replicated
// stores, splits misaligned half/word accesses into byte beats and returns extended loads.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_split,
  output logic        ram_we,
  output logic [2:0]  ram_mode,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] address;
    logic [31:0] wdata;
  } ram_cmd_t;

  localparam ram_cmd_t CMD_IDLE = '{we: 1'b0, mode: 3'b100, address: 32'd0, wdata: 32'd0};

  state_t      state_r, state_nxt;
  logic        we_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic        split_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  beat_r;
  logic [1:0]  last_r;
  logic [31:0] buf_r;
  ram_cmd_t    cmd_r, cmd_nxt;
  logic        ready_r;
  logic        resp_valid_r, resp_valid_nxt;
  logic [31:0] resp_rdata_r, resp_rdata_nxt;
  logic        resp_err_r, resp_err_nxt;
  logic        resp_split_r, resp_split_nxt;
  logic        accept_s;
  logic        mis_s;
  logic [31:0] asm_s;

  // RAM command for one beat; split beats are single bytes walking up from the base address.
  function automatic ram_cmd_t beat_cmd(input logic        we,
                                        input logic [1:0]  size,
                                        input logic        split,
                                        input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        input logic [1:0]  beat);
    ram_cmd_t    cmd;
    logic [31:0] sel;
    sel    = wdata >> {beat, 3'b000};
    cmd.we = we;
    if (split) begin
      cmd.address = addr + {30'd0, beat};
      cmd.mode    = 3'b001;
      cmd.wdata   = {4{sel[7:0]}};
    end else begin
      cmd.address = addr;
      case (size)
        2'b00: begin
          cmd.mode  = 3'b001;
          cmd.wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          cmd.mode  = 3'b010;
          cmd.wdata = {2{wdata[15:0]}};
        end
        default: begin
          cmd.mode  = 3'b100;
          cmd.wdata = wdata;
        end
      endcase
    end
    return cmd;
  endfunction

  // The RAM already sign-extends aligned byte/half reads; split results are extended here.
  function automatic logic [31:0] load_result(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic        split,
                                              input logic [31:0] raw);
    logic [31:0] res;
    case (size)
      2'b00: begin
        if (uns) begin
          res = {24'd0, raw[7:0]};
        end else if (split) begin
          res = {{24{raw[7]}}, raw[7:0]};
        end else begin
          res = raw;
        end
      end
      2'b01: begin
        if (uns) begin
          res = {16'd0, raw[15:0]};
        end else if (split) begin
          res = {{16{raw[15]}}, raw[15:0]};
        end else begin
          res = raw;
        end
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  // Next-state, next RAM command and next response values.
  always_comb begin
    state_nxt      = state_r;
    cmd_nxt        = CMD_IDLE;
    accept_s       = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = 32'd0;
    resp_err_nxt   = 1'b0;
    resp_split_nxt = 1'b0;
    mis_s          = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    asm_s          = buf_r;
    asm_s[{beat_r, 3'b000} +: 8] = ram_rdata[7:0];
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (req_size == 2'b11) begin
            state_nxt      = ST_RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
            cmd_nxt   = beat_cmd(req_we, req_size, mis_s, req_addr, req_wdata, 2'd0);
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (beat_r == last_r) begin
          state_nxt      = ST_RESP;
          resp_valid_nxt = 1'b1;
          resp_split_nxt = split_r;
          if (we_r) begin
            resp_rdata_nxt = 32'd0;
          end else begin
            resp_rdata_nxt = load_result(size_r, uns_r, split_r, split_r ? asm_s : ram_rdata);
          end
        end else begin
          state_nxt = ST_ISSUE;
          cmd_nxt   = beat_cmd(we_r, size_r, split_r, addr_r, wdata_r, beat_r + 2'd1);
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, request latch, beat/assembly tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      split_r      <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      beat_r       <= 2'd0;
      last_r       <= 2'd0;
      buf_r        <= 32'd0;
      cmd_r        <= CMD_IDLE;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      resp_split_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      cmd_r        <= cmd_nxt;
      ready_r      <= (state_nxt == ST_IDLE);
      resp_valid_r <= resp_valid_nxt;
      resp_rdata_r <= resp_rdata_nxt;
      resp_err_r   <= resp_err_nxt;
      resp_split_r <= resp_split_nxt;
      if (accept_s) begin
        we_r    <= req_we;
        size_r  <= req_size;
        uns_r   <= req_unsigned;
        split_r <= mis_s;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        beat_r  <= 2'd0;
        buf_r   <= 32'd0;
        last_r  <= mis_s ? ((req_size == 2'b01) ? 2'd1 : 2'd3) : 2'd0;
      end else if (state_r == ST_ISSUE) begin
        beat_r <= beat_r + 2'd1;
        if (split_r && !we_r) begin
          buf_r <= asm_s;
        end
      end
    end
  end

  assign req_ready   = ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_rdata  = resp_rdata_r;
  assign resp_err    = resp_err_r;
  assign resp_split  = resp_split_r;
  assign ram_we      = cmd_r.we;
  assign ram_mode    = cmd_r.mode;
  assign ram_address = cmd_r.address;
  assign ram_wdata   = cmd_r.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-lane RAM model, flat byte-array reference
// memory, directed test-plan steps followed by randomized requests.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, resp_split;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [2:0]  ram_mode;
  logic [31:0] ram_address, ram_wdata, ram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  m;
    logic [31:0] d;
  } beat_t;
  beat_t wlog[$];

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_split(resp_split),
    .ram_we(ram_we), .ram_mode(ram_mode), .ram_address(ram_address), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Byte-lane RAM: picks the lane selected by the low address bits.
  function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [2:0] m);
    logic [31:0] base;
    logic [15:0] h;
    logic [7:0]  b;
    case (m)
      3'b001: begin
        b = ram_byte(a);
        return {{24{b[7]}}, b};
      end
      3'b010: begin
        base = {a[31:1], 1'b0};
        h = {ram_byte(base + 32'd1), ram_byte(base)};
        return {{16{h[15]}}, h};
      end
      default: begin
        base = {a[31:2], 2'b00};
        return {ram_byte(base + 32'd3), ram_byte(base + 32'd2), ram_byte(base + 32'd1), ram_byte(base)};
      end
    endcase
  endfunction

  task automatic ram_write(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d);
    logic [31:0] base;
    int sh;
    case (m)
      3'b001: begin
        sh = 8 * int'(a[1:0]);
        ram_mem[a] = d[sh +: 8];
      end
      3'b010: begin
        base = {a[31:1], 1'b0};
        sh = a[1] ? 16 : 0;
        ram_mem[base] = d[sh +: 8];
        ram_mem[base + 32'd1] = d[sh + 8 +: 8];
      end
      default: begin
        base = {a[31:2], 2'b00};
        for (int i = 0; i < 4; i++) ram_mem[base + 32'(i)] = d[8 * i +: 8];
      end
    endcase
  endtask

  always @(posedge clk) if (ram_we) ram_write(ram_address, ram_mode, ram_wdata);
  always @(negedge clk) ram_rdata = ram_read(ram_address, ram_mode);
  always @(negedge clk) if (rst_n && ram_we) wlog.push_back('{ram_address, ram_mode, ram_wdata});

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Reference load: little-endian bytes from the flat memory, then extension.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
    logic [31:0] v = 32'd0;
    int n = size_bytes(size);
    for (int i = 0; i < n; i++) v |= 32'(ref_byte(a + 32'(i))) << (8 * i);
    if (size == 2'b10 || uns) return v;
    if (size == 2'b00) return {{24{v[7]}}, v[7:0]};
    return {{16{v[15]}}, v[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bit ill, split;
    int n, exp_lat, exp_nw, cyc;
    logic [31:0] exp_rd, ea, ed;
    logic [2:0] em;
    logic [7:0] b;
    ill = (size == 2'b11);
    n = size_bytes(size);
    split = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    exp_lat = ill ? 1 : split ? ((size == 2'b01) ? 3 : 5) : 2;
    exp_rd = (we || ill) ? 32'd0 : ref_load(addr, size, uns);
    exp_nw = (we && !ill) ? (split ? n : 1) : 0;
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    wlog.delete();
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!resp_valid) check("ready_busy", {31'd0, req_ready}, 32'd0);
    end while (!resp_valid && cyc < 12);
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", {31'd0, resp_err}, {31'd0, ill});
    check("resp_split", {31'd0, resp_split}, {31'd0, split});
    req_valid = 1'b0;
    check("we_beats", 32'(wlog.size()), 32'(exp_nw));
    for (int i = 0; i < wlog.size() && i < exp_nw; i++) begin
      b = wdata[8 * i +: 8];
      if (split) begin
        ea = addr + 32'(i); em = 3'b001; ed = {4{b}};
      end else begin
        ea = addr;
        em = (size == 2'b00) ? 3'b001 : (size == 2'b01) ? 3'b010 : 3'b100;
        ed = (size == 2'b00) ? {4{wdata[7:0]}} : (size == 2'b01) ? {2{wdata[15:0]}} : wdata;
      end
      check("beat_addr", wlog[i].a, ea);
      check("beat_mode", {29'd0, wlog[i].m}, {29'd0, em});
      check("beat_wdata", wlog[i].d, ed);
    end
    if (we && !ill) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8 * i +: 8];
    @(negedge clk);
    check("pulse_end", {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_ram_mode"}, {29'd0, ram_mode}, 32'd4);
    check({tag, "_ram_address"}, ram_address, 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    int r;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_split", {31'd0, resp_split}, 32'd0);
    rst_n = 1'b1;

    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
    run_req(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_0080);
    run_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0);
    run_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0);
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0201, 32'h1122_3344);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0201, 32'd0);
    run_req(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_A5F0);
    run_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_req(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'd0);
    run_req(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_7E01);
    run_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0);
    run_req(1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'h1234_5678);
    run_req(1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'd0);

    // Reset during beat 2 of a split word store: only bytes 0 and 1 land.
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0301, 32'hAABB_CCDD);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0301; req_wdata = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_beat_we", {31'd0, ram_we}, 32'd1);
    check("mid_beat_addr", ram_address, 32'h0000_0303);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    ref_mem[32'h0000_0301] = 8'h44;
    ref_mem[32'h0000_0302] = 8'h33;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0301, 32'd0);
    run_req(1'b0, 2'b00, 1'b1, 32'h0000_0303, 32'd0);

    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 7));
      ra = (($urandom % 2) == 0) ? 32'h0000_0500 : 32'hFFFF_FFF8;
      ra = ra + 32'($urandom_range(0, 15));
      run_req(1'($urandom % 2), (r == 7) ? 2'b11 : 2'(r % 3), 1'($urandom % 2), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
